mem_bus_master: RTL and testbench

Initiator for the shared-bus synchronous memory. It accepts single-word read or write requests on a valid/ready interface and sequences `mem_addr`, the bidirectional `mem_data` bus, `mem_read` and the edge-sensitive `mem_write` strobe. It returns read data and write completions on a one-cycle response pulse. It sits between the VeriRISC controller/datapath and the memory, and is the only agent that may drive `mem_data` from the core side.

---
 rtl/mem_bus_pkg.sv | 22 ++
 rtl/mem_bus_master.sv | 101 ++++++++++
 tb/tb_mem_bus_master.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the shared-bus memory initiator and its users.
package mem_bus_pkg;

    // Default bus geometry, shared with the memory and the testbench.
    localparam int unsigned MEM_DWIDTH = 8;
    localparam int unsigned MEM_AWIDTH = 5;

    // Transaction sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WR_SETUP,
        ST_WR_STROBE,
        ST_WR_HOLD
    } mem_bus_state_e;

    // The core side owns the data bus for the whole write window.
    function automatic logic drives_bus(input mem_bus_state_e s);
        return (s == ST_WR_SETUP) || (s == ST_WR_STROBE) || (s == ST_WR_HOLD);
    endfunction

endpackage

// File: rtl/mem_bus_master.sv
// Single-word read/write initiator for the shared-bus synchronous memory.
// Requests arrive on valid/ready; completions leave as a one-cycle rsp_valid.
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter int unsigned DWIDTH = MEM_DWIDTH,
    parameter int unsigned AWIDTH = MEM_AWIDTH
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic [AWIDTH-1:0] mem_addr,
    inout  wire  [DWIDTH-1:0] mem_data,
    output logic              mem_read,
    output logic              mem_write
);

    mem_bus_state_e    state_q, state_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              drive_q, drive_d;
    logic              accept;

    assign accept = (state_q == ST_IDLE) && req_valid;

    // State register.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing: read is one cycle, write is setup/strobe/hold.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:      if (req_valid) state_d = req_write ? ST_WR_SETUP : ST_READ;
            ST_READ:      state_d = ST_IDLE;
            ST_WR_SETUP:  state_d = ST_WR_STROBE;
            ST_WR_STROBE: state_d = ST_WR_HOLD;
            ST_WR_HOLD:   state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Output decode: bus controls are decoded from the next state so that
    // they can be registered and leave the block glitch-free.
    always_comb begin
        mem_read_d  = (state_d == ST_READ);
        mem_write_d = (state_d == ST_WR_STROBE);
        drive_d     = drives_bus(state_d);
        rsp_valid_d = (state_q == ST_READ) || (state_q == ST_WR_HOLD);
        addr_d      = accept ? req_addr : addr_q;
        wdata_d     = accept ? req_wdata : wdata_q;
        rdata_d     = (state_q == ST_READ) ? mem_data : rdata_q;
    end

    // Registered outputs and transaction payload.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            drive_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
        end else begin
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            drive_q     <= drive_d;
            rsp_valid_q <= rsp_valid_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign mem_addr  = addr_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;

    // Only tristate driver on the core side of the bus.
    assign mem_data = drive_q ? wdata_q : 'z;

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master with a behavioural memory on the bus.
module tb_mem_bus_master;
    import mem_bus_pkg::*;

    localparam int unsigned DW = MEM_DWIDTH;
    localparam int unsigned AW = MEM_AWIDTH;

    logic          clk = 1'b0;
    logic          rst_;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] mem_addr;
    wire  [DW-1:0] mem_data;
    logic          mem_read;
    logic          mem_write;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] mem_array [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem   [0:(1<<AW)-1];
    logic [DW-1:0] last_rdata;

    logic          tr_write;
    logic [AW-1:0] tr_addr;
    logic [DW-1:0] tr_data;

    mem_bus_master #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk       (clk),
        .rst_      (rst_),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_read  (mem_read),
        .mem_write (mem_write)
    );

    // Memory: asynchronous read while enabled, capture on mem_write rising.
    assign mem_data = mem_read ? mem_array[mem_addr] : 'z;
    always @(posedge mem_write) mem_array[mem_addr] <= mem_data;

    // Released bus reads as zero.
    for (genvar i = 0; i < DW; i++) begin : g_pd
        pulldown pd (mem_data[i]);
    end

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request and wait (bounded) until it is taken at a rising edge.
    task automatic accept(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output int waited);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        waited    = 0;
        while (!req_ready && waited < 20) begin
            tick();
            waited++;
        end
        check("accept_timeout", {31'd0, req_ready}, 32'd1);
        if (w) ref_mem[a] = d;
        tick();
    endtask

    // Wait (bounded) for the response and check latency and read data.
    task automatic finish_rsp(input logic w, input logic [DW-1:0] exp_rdata,
                              input logic keep_valid, input string tag);
        int n;
        if (!keep_valid) req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 12) begin
            tick();
            n++;
        end
        check({tag, "_rsp_seen"}, {31'd0, rsp_valid}, 32'd1);
        check({tag, "_latency"}, n, w ? 32'd4 : 32'd2);
        check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        if (!w) last_rdata = exp_rdata;
        check({tag, "_rdata"}, rsp_rdata, last_rdata);
    endtask

    // Bus discipline monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_ === 1'b1) begin
            if (req_ready) begin
                check("mon_idle_bus", mem_data, 0);
                check("mon_idle_read", {31'd0, mem_read}, 0);
                check("mon_idle_write", {31'd0, mem_write}, 0);
            end else begin
                check("mon_addr_stable", mem_addr, tr_addr);
                if (tr_write) begin
                    check("mon_wdata_stable", mem_data, tr_data);
                    check("mon_no_read_in_write", {31'd0, mem_read}, 0);
                end else begin
                    check("mon_read_en", {31'd0, mem_read}, 1);
                    check("mon_read_bus", mem_data, mem_array[tr_addr]);
                    check("mon_no_write_in_read", {31'd0, mem_write}, 0);
                end
            end
            if (req_valid && req_ready) begin
                tr_write <= req_write;
                tr_addr  <= req_addr;
                tr_data  <= req_wdata;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;
        logic          rw;

        for (int i = 0; i < (1 << AW); i++) begin
            mem_array[i] = '0;
            ref_mem[i]   = '0;
        end
        last_rdata = '0;
        tr_write   = 1'b0;
        tr_addr    = '0;
        tr_data    = '0;
        rst_       = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;

        // Reset state, sampled mid-cycle.
        #12;
        check("rst_ready", {31'd0, req_ready}, 1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_read", {31'd0, mem_read}, 0);
        check("rst_write", {31'd0, mem_write}, 0);
        check("rst_bus", mem_data, 0);
        tick();
        rst_ = 1'b1;
        tick();

        // Write 0xA5 to 0x03, cycle by cycle.
        accept(1'b1, 5'h03, 8'hA5, w);
        req_valid = 1'b0;
        check("wr_setup_write", {31'd0, mem_write}, 0);
        check("wr_setup_bus", mem_data, 8'hA5);
        check("wr_setup_addr", mem_addr, 5'h03);
        check("wr_setup_ready", {31'd0, req_ready}, 0);
        tick();
        check("wr_strobe_write", {31'd0, mem_write}, 1);
        check("wr_strobe_rsp", {31'd0, rsp_valid}, 0);
        tick();
        check("wr_hold_write", {31'd0, mem_write}, 0);
        check("wr_hold_bus", mem_data, 8'hA5);
        check("wr_hold_rsp", {31'd0, rsp_valid}, 0);
        tick();
        check("wr_done_rsp", {31'd0, rsp_valid}, 1);
        check("wr_done_bus", mem_data, 0);
        check("wr_done_write", {31'd0, mem_write}, 0);
        check("wr_rdata_kept", rsp_rdata, 0);

        // Read it back, accepted in the write's response cycle.
        accept(1'b0, 5'h03, 8'h00, w);
        check("rd_accept_wait", w, 0);
        req_valid = 1'b0;
        check("rd_read_en", {31'd0, mem_read}, 1);
        check("rd_pending_rsp", {31'd0, rsp_valid}, 0);
        tick();
        check("rd_rsp", {31'd0, rsp_valid}, 1);
        check("rd_data", rsp_rdata, 8'hA5);
        check("rd_read_off", {31'd0, mem_read}, 0);
        last_rdata = 8'hA5;
        tick();
        check("rsp_one_cycle", {31'd0, rsp_valid}, 0);

        // Back-to-back with req_valid held continuously.
        accept(1'b1, 5'h1F, 8'hFF, w);
        finish_rsp(1'b1, 8'h00, 1'b1, "b2b_w0");
        accept(1'b1, 5'h00, 8'h01, w);
        check("b2b_w1_wait", w, 0);
        finish_rsp(1'b1, 8'h00, 1'b1, "b2b_w1");
        accept(1'b0, 5'h1F, 8'h00, w);
        check("b2b_r0_wait", w, 0);
        finish_rsp(1'b0, 8'hFF, 1'b1, "b2b_r0");
        accept(1'b0, 5'h00, 8'h00, w);
        check("b2b_r1_wait", w, 0);
        finish_rsp(1'b0, 8'h01, 1'b0, "b2b_r1");
        tick();

        // Backpressure: read presented during an in-flight write.
        accept(1'b1, 5'h10, 8'h5A, w);
        accept(1'b0, 5'h03, 8'h77, w);
        check("bp_wait_cycles", w, 3);
        finish_rsp(1'b0, 8'hA5, 1'b0, "bp_read");
        accept(1'b0, 5'h10, 8'h00, w);
        finish_rsp(1'b0, 8'h5A, 1'b0, "bp_readback");

        // Mixed random traffic under the monitor.
        for (int i = 0; i < 40; i++) begin
            rw = 1'(($urandom_range(0, 1)));
            ra = AW'($urandom_range(0, (1 << AW) - 1));
            rd = DW'($urandom_range(1, 255));
            if (rw) begin
                accept(1'b1, ra, rd, w);
                finish_rsp(1'b1, 8'h00, 1'b0, "rnd_wr");
            end else begin
                accept(1'b0, ra, 8'h00, w);
                finish_rsp(1'b0, ref_mem[ra], 1'b0, "rnd_rd");
            end
            if ($urandom_range(0, 2) == 0) tick();
        end

        // Reset during WR_SETUP leaves memory unchanged.
        accept(1'b1, 5'h07, 8'h11, w);
        finish_rsp(1'b1, 8'h00, 1'b0, "pre_wr");
        accept(1'b1, 5'h07, 8'h3C, w);
        req_valid = 1'b0;
        check("abort_in_setup", mem_data, 8'h3C);
        #3;
        rst_ = 1'b0;
        #1;
        check("abort_ready", {31'd0, req_ready}, 1);
        check("abort_write", {31'd0, mem_write}, 0);
        check("abort_read", {31'd0, mem_read}, 0);
        check("abort_addr", mem_addr, 0);
        check("abort_rdata", rsp_rdata, 0);
        check("abort_bus", mem_data, 0);
        ref_mem[7] = 8'h11;
        last_rdata = '0;
        tick();
        rst_ = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("abort_no_rsp", {31'd0, rsp_valid}, 0);
            check("abort_no_strobe", {31'd0, mem_write}, 0);
            tick();
        end
        accept(1'b0, 5'h07, 8'h00, w);
        finish_rsp(1'b0, 8'h11, 1'b0, "abort_readback");
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
